// File: rtl/ofm_out_sched_if.sv
// Egress scheduler bus bundle: ctrl/data FIFO heads, checksum-config handshake, MAC stream.
// The master modport is the scheduler side; slave is the FIFO/engine/MAC side.
interface ofm_out_sched_if;
    logic [63:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty;
    logic        ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty;
    logic        data_fifo_rden;
    logic        cs_cfg_valid;
    logic        cs_cfg_ready;
    logic [15:0] cs_cfg_begin;
    logic [15:0] cs_cfg_insert;
    logic [15:0] cs_cfg_init;
    logic [1:0]  cs_cfg_cntrl;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic        tx_tready;

    modport master (
        input  ctrl_fifo_rdata, ctrl_fifo_empty,
        output ctrl_fifo_rden,
        input  data_fifo_rdata, data_fifo_empty,
        output data_fifo_rden,
        output cs_cfg_valid, cs_cfg_begin, cs_cfg_insert, cs_cfg_init, cs_cfg_cntrl,
        input  cs_cfg_ready,
        output tx_tdata, tx_tkeep, tx_tvalid, tx_tlast,
        input  tx_tready
    );

    modport slave (
        output ctrl_fifo_rdata, ctrl_fifo_empty,
        input  ctrl_fifo_rden,
        output data_fifo_rdata, data_fifo_empty,
        input  data_fifo_rden,
        input  cs_cfg_valid, cs_cfg_begin, cs_cfg_insert, cs_cfg_init, cs_cfg_cntrl,
        output cs_cfg_ready,
        input  tx_tdata, tx_tkeep, tx_tvalid, tx_tlast,
        output tx_tready
    );
endinterface

// File: rtl/ofm_out_sched.sv
// TX egress scheduler: pops one checksum ctrl entry per frame, loads the checksum engine,
// streams the stored frame to the MAC and inserts an inter-frame idle gap.
module ofm_out_sched #(
    parameter int C_IFG_CYCLES = 3,
    parameter int C_CNT_W      = 32
) (
    input  logic                 mm2s_clk,
    input  logic                 mm2s_resetn,
    ofm_out_sched_if.master      bus,
    output logic [C_CNT_W-1:0]   frame_cnt,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_DATA, S_GAP} state_t;

    localparam int               GAP_W    = (C_IFG_CYCLES > 1) ? $clog2(C_IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (C_IFG_CYCLES > 0) ? GAP_W'(C_IFG_CYCLES - 1) : '0;

    state_t               r_state;
    state_t               w_next_state;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [C_CNT_W-1:0]   r_frame_cnt;
    logic                 r_cfg_valid;
    logic [15:0]          r_cfg_begin;
    logic [15:0]          r_cfg_insert;
    logic [15:0]          r_cfg_init;
    logic [1:0]           r_cfg_cntrl;

    logic                 w_ctrl_pop;
    logic                 w_bypass;
    logic                 w_cfg_fire;
    logic                 w_tx_valid;
    logic                 w_tx_fire;
    logic                 w_last_fire;
    logic                 w_unused_ctrl_hi;

    // A zero mode field means the frame needs no offload, so the config handshake is skipped.
    assign w_bypass         = (bus.ctrl_fifo_rdata[49:48] == 2'b00);
    assign w_cfg_fire       = r_cfg_valid && bus.cs_cfg_ready;
    assign w_tx_fire        = w_tx_valid && bus.tx_tready;
    assign w_last_fire      = w_tx_fire && bus.data_fifo_rdata[72];
    assign w_unused_ctrl_hi = ^bus.ctrl_fifo_rdata[63:50];

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_ctrl_pop   = 1'b0;
        w_tx_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.ctrl_fifo_empty) begin
                    // Gated by reset so the FIFO is never popped while it is being flushed.
                    w_ctrl_pop   = mm2s_resetn;
                    w_next_state = w_bypass ? S_DATA : S_CFG;
                end
            end
            S_CFG: begin
                if (w_cfg_fire) w_next_state = S_DATA;
            end
            S_DATA: begin
                w_tx_valid = !bus.data_fifo_empty;
                if (w_last_fire) w_next_state = (C_IFG_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == '0) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= '0;
            r_frame_cnt  <= '0;
            r_cfg_valid  <= 1'b0;
            r_cfg_begin  <= '0;
            r_cfg_insert <= '0;
            r_cfg_init   <= '0;
            r_cfg_cntrl  <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_ctrl_pop) begin
                r_cfg_begin  <= bus.ctrl_fifo_rdata[15:0];
                r_cfg_insert <= bus.ctrl_fifo_rdata[31:16];
                r_cfg_init   <= bus.ctrl_fifo_rdata[47:32];
                r_cfg_cntrl  <= bus.ctrl_fifo_rdata[49:48];
                r_cfg_valid  <= !w_bypass;
            end else if (w_cfg_fire) begin
                r_cfg_valid  <= 1'b0;
            end

            if (w_last_fire) begin
                r_frame_cnt <= r_frame_cnt + C_CNT_W'(1);
                r_gap_cnt   <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt   <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    // Data path is straight from the FWFT head; FIFO holds the word stable until popped.
    assign bus.ctrl_fifo_rden = w_ctrl_pop;
    assign bus.data_fifo_rden = w_tx_fire;
    assign bus.tx_tvalid      = w_tx_valid;
    assign bus.tx_tdata       = bus.data_fifo_rdata[63:0];
    assign bus.tx_tkeep       = bus.data_fifo_rdata[71:64];
    assign bus.tx_tlast       = bus.data_fifo_rdata[72];

    assign bus.cs_cfg_valid   = r_cfg_valid;
    assign bus.cs_cfg_begin   = r_cfg_begin;
    assign bus.cs_cfg_insert  = r_cfg_insert;
    assign bus.cs_cfg_init    = r_cfg_init;
    assign bus.cs_cfg_cntrl   = r_cfg_cntrl;

    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ofm_out_sched.sv
// Bench for ofm_out_sched: FWFT FIFO models, randomized handshakes and a frame-level
// reference model predicting pops, config handshakes, beats, gaps and frame count.
module tb_ofm_out_sched;
    localparam int IFG = 3;
    localparam int CW  = 4;

    logic          mm2s_clk;
    logic          mm2s_resetn;
    logic [CW-1:0] frame_cnt;
    logic          busy;

    ofm_out_sched_if bus();

    ofm_out_sched #(.C_IFG_CYCLES(IFG), .C_CNT_W(CW)) dut (
        .mm2s_clk   (mm2s_clk),
        .mm2s_resetn(mm2s_resetn),
        .bus        (bus),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    initial mm2s_clk = 1'b0;
    always #5 mm2s_clk = ~mm2s_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents as seen by the DUT, plus the expected outgoing beat stream
    logic [63:0] ctrl_q[$];
    logic [72:0] data_q[$];
    logic [72:0] exp_beats[$];

    // Frame-level model: a frame is open from its ctrl pop until its last beat is taken,
    // then IFG idle cycles must pass before the next pop is allowed.
    logic        open_f;
    logic        cfg_pending;
    int          gap_left;
    int          frames_done;
    logic [63:0] cur_cfg;

    logic pop_c, pop_d;
    int   n_cfg_cyc, n_ctrl_pop, n_data_pop;
    int   p_tready, p_cfg_ready, p_hold;
    logic pat_en;
    logic [3:0] pat;
    int   pat_idx;

    task automatic check(input string tag, input logic [72:0] act, input logic [72:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic update_fifo();
        bus.ctrl_fifo_empty = (ctrl_q.size() == 0);
        bus.ctrl_fifo_rdata = (ctrl_q.size() == 0) ? 64'h0 : ctrl_q[0];
        bus.data_fifo_empty = (data_q.size() == 0) || ($urandom_range(99) < p_hold);
        bus.data_fifo_rdata = (data_q.size() == 0) ? 73'h0 : data_q[0];
    endtask

    task automatic push_frame(input logic [1:0] cn, input logic [15:0] bg, input logic [15:0] ins,
                              input logic [15:0] ini, input int nb);
        logic [72:0] beat;
        for (int i = 0; i < nb; i++) begin
            beat[63:0]  = {$urandom, $urandom};
            beat[71:64] = (i == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            beat[72]    = (i == nb - 1);
            data_q.push_back(beat);
            exp_beats.push_back(beat);
        end
        ctrl_q.push_back({14'($urandom), cn, ini, ins, bg});
        update_fifo();
    endtask

    task automatic model_reset();
        open_f = 1'b0; cfg_pending = 1'b0; gap_left = 0; frames_done = 0;
        ctrl_q.delete(); data_q.delete(); exp_beats.delete();
        update_fifo();
    endtask

    // Called at the falling edge: compare against the model, then advance the model.
    task automatic monitor();
        logic exp_rden, exp_tv, exp_cfg;
        logic [72:0] b;
        exp_rden = !open_f && gap_left == 0 && ctrl_q.size() != 0;
        exp_cfg  = open_f && cfg_pending;
        exp_tv   = open_f && !cfg_pending && !bus.data_fifo_empty;
        check("ctrl_rden", bus.ctrl_fifo_rden, exp_rden);
        check("busy", busy, open_f || gap_left != 0);
        check("cfg_valid", bus.cs_cfg_valid, exp_cfg);
        if (exp_cfg)
            check("cfg_fields", {bus.cs_cfg_cntrl, bus.cs_cfg_init, bus.cs_cfg_insert, bus.cs_cfg_begin},
                  cur_cfg[49:0]);
        check("tvalid", bus.tx_tvalid, exp_tv);
        check("data_rden", bus.data_fifo_rden, exp_tv && bus.tx_tready);
        if (exp_tv) begin
            if (exp_beats.size() != 0)
                check("beat", {bus.tx_tlast, bus.tx_tkeep, bus.tx_tdata}, exp_beats[0]);
            else
                check("beat_extra", 1'b1, 1'b0);
        end
        check("frame_cnt", frame_cnt, frames_done[CW-1:0]);

        pop_c = bus.ctrl_fifo_rden && ctrl_q.size() != 0;
        pop_d = bus.data_fifo_rden && data_q.size() != 0;
        n_cfg_cyc  += int'(bus.cs_cfg_valid);
        n_ctrl_pop += int'(bus.ctrl_fifo_rden);
        n_data_pop += int'(bus.data_fifo_rden);

        if (gap_left != 0) gap_left--;
        if (exp_rden) begin
            cur_cfg     = ctrl_q[0];
            open_f      = 1'b1;
            cfg_pending = (ctrl_q[0][49:48] != 2'b00);
        end else if (exp_cfg && bus.cs_cfg_ready) begin
            cfg_pending = 1'b0;
        end
        if (exp_tv && bus.tx_tready && exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            if (b[72]) begin
                frames_done++;
                open_f   = 1'b0;
                gap_left = IFG;
            end
        end
    endtask

    task automatic step();
        @(negedge mm2s_clk);
        monitor();
        @(posedge mm2s_clk);
        #1;
        if (pop_c) void'(ctrl_q.pop_front());
        if (pop_d) void'(data_q.pop_front());
        if (pat_en) begin
            bus.tx_tready = pat[pat_idx % 4];
            pat_idx++;
        end else begin
            bus.tx_tready = ($urandom_range(99) < p_tready);
        end
        bus.cs_cfg_ready = ($urandom_range(99) < p_cfg_ready);
        update_fifo();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(ctrl_q.size() == 0 && exp_beats.size() == 0 && !open_f && gap_left == 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1'b1, 1'b0);
    endtask

    task automatic clr_counts();
        n_cfg_cyc = 0; n_ctrl_pop = 0; n_data_pop = 0;
    endtask

    initial begin
        int pushed;
        mm2s_resetn = 1'b0;
        p_tready = 100; p_cfg_ready = 100; p_hold = 0;
        pat_en = 1'b0; pat = 4'b1001; pat_idx = 0;
        pop_c = 1'b0; pop_d = 1'b0;
        bus.tx_tready = 1'b1;
        bus.cs_cfg_ready = 1'b1;
        model_reset();
        clr_counts();

        // Frame 1: offload config, 3 beats; ctrl entry already waiting while in reset
        push_frame(2'b01, 16'd14, 16'd50, 16'h1234, 3);
        repeat (2) @(posedge mm2s_clk);
        #2;
        check("rst_ctrl_rden", bus.ctrl_fifo_rden, 1'b0);
        check("rst_tvalid", bus.tx_tvalid, 1'b0);
        check("rst_data_rden", bus.data_fifo_rden, 1'b0);
        check("rst_cfg_valid", bus.cs_cfg_valid, 1'b0);
        check("rst_cfg_fields", {bus.cs_cfg_cntrl, bus.cs_cfg_init, bus.cs_cfg_insert, bus.cs_cfg_begin}, 50'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_cnt", frame_cnt, 4'd0);
        @(posedge mm2s_clk);
        #1;
        mm2s_resetn = 1'b1;
        drain(200);
        check("f1_frame_cnt", frame_cnt, 4'd1);
        check("f1_ctrl_pops", n_ctrl_pop, 1);
        check("f1_cfg_cycles", n_cfg_cyc, 1);
        check("f1_data_pops", n_data_pop, 3);

        // Bypass frame: config handshake never happens
        clr_counts();
        push_frame(2'b00, 16'h1, 16'h2, 16'h3, 2);
        drain(200);
        check("byp_cfg_cycles", n_cfg_cyc, 0);
        check("byp_data_pops", n_data_pop, 2);

        // Ready pattern 1,0,0,1 across a 4-beat frame
        clr_counts();
        pat_en = 1'b1;
        push_frame(2'b10, 16'h20, 16'h40, 16'hBEEF, 4);
        drain(300);
        pat_en = 1'b0;
        bus.tx_tready = 1'b1;
        check("stall_data_pops", n_data_pop, 4);

        // Two queued frames: the gap model pins the second pop to the exact cycle
        clr_counts();
        push_frame(2'b00, 16'h0, 16'h0, 16'h0, 2);
        push_frame(2'b00, 16'h0, 16'h0, 16'h0, 2);
        drain(200);
        check("two_frame_cnt", frame_cnt, 4'd5);
        check("two_ctrl_pops", n_ctrl_pop, 2);

        // Checksum engine stalls for many cycles: config held, no data popped
        clr_counts();
        p_cfg_ready = 0;
        bus.cs_cfg_ready = 1'b0;
        push_frame(2'b11, 16'hA5A5, 16'h5A5A, 16'hFFFF, 3);
        repeat (12) step();
        check("cfgwait_no_pop", n_data_pop, 0);
        check("cfgwait_valid", bus.cs_cfg_valid, 1'b1);
        p_cfg_ready = 100;
        drain(200);

        // Randomized traffic with random backpressure and FIFO underrun
        p_tready = 60; p_cfg_ready = 50; p_hold = 20;
        pushed = 0;
        for (int cyc = 0; cyc < 6000 && pushed < 30; cyc++) begin
            if (ctrl_q.size() < 3 && $urandom_range(99) < 30) begin
                push_frame(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, 6));
                pushed++;
            end
            step();
        end
        drain(3000);
        check("rand_frames", pushed, 30);
        p_tready = 100; p_cfg_ready = 100; p_hold = 0;
        bus.tx_tready = 1'b1;

        // Reset while beat 2 of 5 is presented
        push_frame(2'b00, 16'h0, 16'h0, 16'h0, 5);
        for (int i = 0; i < 50 && exp_beats.size() != 4; i++) step();
        #1;
        check("rst_mid_pre_tvalid", bus.tx_tvalid, 1'b1);
        mm2s_resetn = 1'b0;
        #1;
        check("rst_mid_tvalid", bus.tx_tvalid, 1'b0);
        check("rst_mid_data_rden", bus.data_fifo_rden, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_frame_cnt", frame_cnt, 4'd0);
        model_reset();
        repeat (2) @(posedge mm2s_clk);
        #1;
        mm2s_resetn = 1'b1;

        // Counter wrap: 2^CW frames bring frame_cnt back to zero
        for (int i = 0; i < 16; i++) push_frame(2'b00, 16'h0, 16'h0, 16'h0, 1);
        drain(1000);
        check("wrap_frame_cnt", frame_cnt, 4'd0);
        check("wrap_frames_done", frames_done, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ofm_out_sched.md
Name: ofm_out_sched

Overview:
TX egress scheduler for the 10GE MM2S path. It pops one checksum-control entry from the ctrl FIFO and loads it into the downstream checksum-offload engine. It then streams the matching frame from the data FIFO to the MAC-side AXI-Stream and enforces a minimum idle gap between frames. Ingress writes a ctrl entry only after a frame's last data word, so a non-empty ctrl FIFO means a complete frame is present in the data FIFO (store-and-forward).

Parameters:
C_IFG_CYCLES, 3, idle cycles inserted after each frame's last beat; 0 = back-to-back.
C_CNT_W, 32, width of frame_cnt.

Ports:
mm2s_clk  in  1  clock
mm2s_resetn  in  1  reset, asynchronous, active-low
ctrl_fifo_rdata  in  64  FWFT head: [15:0] CsBegin, [31:16] CsInsert, [47:32] CsInit, [49:48] CsCntrl
ctrl_fifo_empty  in  1  ctrl FIFO empty
ctrl_fifo_rden  out  1  pop ctrl FIFO head
data_fifo_rdata  in  73  FWFT head: [63:0] data, [71:64] keep, [72] last
data_fifo_empty  in  1  data FIFO empty
data_fifo_rden  out  1  pop data FIFO head
cs_cfg_valid  out  1  checksum config valid
cs_cfg_ready  in  1  checksum engine accepts config
cs_cfg_begin  out  16  checksum start offset
cs_cfg_insert  out  16  checksum insert offset
cs_cfg_init  out  16  checksum seed
cs_cfg_cntrl  out  2  checksum mode; 0 = no offload
tx_tdata  out  64  MAC stream data
tx_tkeep  out  8  MAC stream byte enables
tx_tvalid  out  1  MAC stream valid
tx_tlast  out  1  MAC stream last
tx_tready  in  1  MAC stream ready
frame_cnt  out  C_CNT_W  frames sent, wraps modulo 2^C_CNT_W
busy  out  1  high in any state other than S_IDLE

Behaviour:
- States: S_IDLE, S_CFG, S_DATA, S_GAP. All state and registered outputs reset asynchronously.
- Reset values: state S_IDLE; cs_cfg_valid 0; cs_cfg_* 0; frame_cnt 0; gap counter 0; busy 0. tx_tvalid, ctrl_fifo_rden and data_fifo_rden are 0 during reset.
- S_IDLE:
  - If ~ctrl_fifo_empty: ctrl_fifo_rden=1 for exactly one cycle, and cs_cfg_* capture ctrl_fifo_rdata in the same edge.
  - Next state: S_DATA if rdata[49:48]==0 (config bypass), else S_CFG with cs_cfg_valid=1 from the next cycle.
- S_CFG:
  - cs_cfg_valid holds 1 and cs_cfg_* stay stable until cs_cfg_ready.
  - On valid&&ready: cs_cfg_valid goes to 0 next cycle; state goes to S_DATA.
- S_DATA (data path is combinational from the FIFO head):
  - tx_tvalid = ~data_fifo_empty.
  - tx_tdata, tx_tkeep, tx_tlast = data_fifo_rdata fields.
  - data_fifo_rden = tx_tvalid && tx_tready.
  - tx_tvalid must not depend on tx_tready.
  - Once tx_tvalid is asserted, data must not change until accepted (guaranteed by FWFT).
- Last beat accepted (tx_tvalid&&tx_tready&&tx_tlast):
  - frame_cnt increments.
  - Next state is S_GAP with counter loaded to C_IFG_CYCLES-1, or S_IDLE when C_IFG_CYCLES==0.
- S_GAP: counter decrements each cycle; at 0, state goes to S_IDLE. Minimum cycles from last beat to next ctrl_fifo_rden = C_IFG_CYCLES+1.
- Outside S_DATA: tx_tvalid=0 and data_fifo_rden=0. Outside S_IDLE: ctrl_fifo_rden=0.
- Data FIFO empty mid-frame: tx_tvalid drops and the block stalls in S_DATA with no error and no timeout.
- tx_tready low: hold the current beat; no pop.
- Ctrl FIFO empty in S_IDLE: remain idle. A ctrl entry that arrives during S_GAP is not popped until S_IDLE.
- frame_cnt wraps from all-ones to 0.
- Reset mid-frame: return to S_IDLE immediately. The FIFOs share mm2s_resetn and are flushed, so no partial-frame recovery is required.
- Latency, ctrl non-empty to first tx_tvalid:
  - Bypass: 1 cycle.
  - Offload: 2 cycles plus cs_cfg_ready wait.

Test Plan:
- One frame, 3 beats, cntrl=2'b01, begin=14, insert=50, init=0x1234, cs_cfg_ready held high -> cs_cfg_valid high for 1 cycle with those values; then 3 tx beats; tlast on beat 3; frame_cnt=1; ctrl_fifo_rden pulses once.
- cntrl=0 frame -> cs_cfg_valid never asserts; first tx_tvalid 1 cycle after the ctrl pop.
- tx_tready toggled 1,0,0,1 during a 4-beat frame -> no beat lost or duplicated; data_fifo_rden exactly 4 pulses; tx_tdata stable while stalled.
- Two queued frames with C_IFG_CYCLES=3 -> exactly 3 cycles with busy high and tx_tvalid low between tlast of frame 1 and the second ctrl_fifo_rden; frame_cnt=2.
- cs_cfg_ready held low for 10 cycles -> cs_cfg_valid and cs_cfg_* constant; no data pop until the handshake completes.
- mm2s_resetn asserted during beat 2 of 5 -> outputs at reset values within the same cycle; with frame_cnt preset to all-ones by a forced run, the next frame wraps frame_cnt to 0.
